// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains a synchronous FIFO into a valid/ready stream through a 2-entry buffer
module fifo_drain_ctrl #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  err_underflow,
   output logic                  busy
);
   logic [1:0]            occ, occ_n;
   logic                  inflight, head, tail, head_n, pop, push;
   logic [2:0]            credit;
   logic [FIFO_WIDTH-1:0] mem [2];
   logic [FIFO_WIDTH-1:0] head_data;

   assign pop        = m_valid && m_ready;
   assign push       = inflight && !fifo_underflow;
   assign credit     = 3'(occ) + 3'(inflight) - 3'(pop);
   assign fifo_rd_en = !rst && enable && !fifo_empty && credit < 3'd2;
   assign head_n     = head ^ pop;
   assign occ_n      = occ + 2'(push) - 2'(pop);
   // register the next head word so m_data is stable and holds its last value when empty
   assign head_data  = (push && tail == head_n) ? fifo_data_out : mem[head_n];

   always_ff @(posedge clk) begin
      if (rst) begin
         occ           <= '0;
         inflight      <= 1'b0;
         head          <= 1'b0;
         tail          <= 1'b0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         rd_count      <= '0;
         err_underflow <= 1'b0;
         busy          <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         occ      <= occ_n;
         head     <= head_n;
         tail     <= tail ^ push;
         if (occ_n != 2'd0) m_data <= head_data;
         m_valid  <= occ_n != 2'd0;
         rd_count <= rd_count + CNT_WIDTH'(pop);
         if (inflight && fifo_underflow) err_underflow <= 1'b1;
         busy     <= occ_n != 2'd0 || fifo_rd_en;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= fifo_data_out;
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && occ == 2'd2 && !pop));
   end
endmodule
